// File: rtl/servo_bank.sv
// servo_bank: multi-channel servo pulse generator sharing one frame timebase,
// with per-frame slew limiting of each channel's position toward its target.
module servo_bank #(
   parameter int NCH       = 4,
   parameter int PW        = 8,
   parameter int TICK_DIV  = 94,
   parameter int PULSE_MIN = 46,
   parameter int PERIOD    = 2048,
   parameter int STEP      = 4,
   localparam int CHW      = NCH > 1 ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           enable_i,
   input  logic           wr_en_i,
   input  logic [CHW-1:0] wr_ch_i,
   input  logic [PW-1:0]  wr_pos_i,
   output logic           wr_ready_o,
   output logic [NCH-1:0] servo_o,
   output logic           frame_start_o
);
   localparam int CW = $clog2(PERIOD);
   localparam int DW = $clog2(TICK_DIV);
   // Steps larger than the position range behave like an immediate jump.
   localparam int SC = STEP > 2**PW - 1 ? 2**PW - 1 : STEP;
   localparam logic [PW-1:0] STP = PW'(SC);
   localparam logic [PW-1:0] MID = PW'(2**(PW-1));

   generate
      if (PULSE_MIN + 2**PW - 1 >= PERIOD || TICK_DIV < 2) begin : g_bad_cfg
         $error("servo_bank: illegal parameter configuration");
      end
   endgenerate

   logic [DW-1:0]  div_q;
   logic [CW-1:0]  frm_q;
   logic [NCH-1:0] servo_q, servo_d;
   logic           fs_q;
   logic           tic, upd;

   assign tic = div_q == DW'(TICK_DIV - 1);
   assign upd = tic && frm_q == CW'(PERIOD - 1);
   assign wr_ready_o = !upd;
   assign servo_o = servo_q;
   assign frame_start_o = fs_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q   <= '0;
         frm_q   <= '0;
         servo_q <= '0;
         fs_q    <= 1'b0;
      end else begin
         div_q   <= tic ? '0 : div_q + DW'(1);
         if (tic) frm_q <= upd ? '0 : frm_q + CW'(1);
         servo_q <= servo_d;
         fs_q    <= upd;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [PW-1:0] tgt_q, cur_q, cur_d, dif;
      logic          up;
      assign up  = tgt_q > cur_q;
      assign dif = up ? tgt_q - cur_q : cur_q - tgt_q;
      assign cur_d = (STEP == 0 || dif <= STP) ? tgt_q : up ? cur_q + STP : cur_q - STP;
      assign servo_d[i] = enable_i && (frm_q < CW'(PULSE_MIN) + CW'(cur_q));
      // Out-of-range channel indices never match, so such writes handshake but do nothing.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            tgt_q <= MID;
            cur_q <= MID;
         end else begin
            if (wr_en_i && !upd && wr_ch_i == CHW'(i)) tgt_q <= wr_pos_i;
            if (upd) cur_q <= cur_d;
         end
      end
   end
endmodule

// File: doc/servo_bank.md
SERVO_BANK -- requirements
Module: servo_bank

Interface
REQ-001 Parameter NCH, default 4: number of servo channels, 1..16.
REQ-002 Parameter PW, default 8: position width in bits; position 0..2^PW-1.
REQ-003 Parameter TICK_DIV, default 94: system clocks per pulse tick, >= 2.
REQ-004 Parameter PULSE_MIN, default 46: pulse width in ticks at position 0.
REQ-005 Parameter PERIOD, default 2048: frame length in ticks; PULSE_MIN + 2^PW - 1 < PERIOD is a legal-config rule, checked by elaboration assertion.
REQ-006 Parameter STEP, default 4: max position change per frame; 0 = jump straight to target.
REQ-007 clk  in  1  system clock; all state on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 enable  in  1  global output enable.
REQ-010 wr_en  in  1  write request (valid).
REQ-011 wr_ch  in  max(1,clog2(NCH))  target channel index.
REQ-012 wr_pos  in  PW  target position.
REQ-013 wr_ready  out  1  write accept (ready).
REQ-014 servo  out  NCH  registered pulse outputs, bit i = channel i.
REQ-015 frame_start  out  1  one-clock pulse at each frame wrap.

Function
REQ-016 Tick divider counts 0..TICK_DIV-1 and wraps; tic asserts for exactly one clk when divider = TICK_DIV-1.
REQ-017 Frame counter (width clog2(PERIOD)) increments on tic only, wraps PERIOD-1 -> 0; no other wrap.
REQ-018 Update cycle = cycle where tic is high and frame counter = PERIOD-1; frame_start is registered high for the one clk following the update cycle.
REQ-019 Each channel holds target[i] and current[i], both PW bits.
REQ-020 wr_ready is high in every cycle except the update cycle.
REQ-021 Write accepted iff wr_en and wr_ready in same cycle: target[wr_ch] <= wr_pos; other channels unchanged.
REQ-022 wr_en while wr_ready low is not queued; requester holds wr_en/wr_ch/wr_pos until accepted.
REQ-023 wr_ch >= NCH: write handshakes (accepted) but changes nothing.
REQ-024 On update cycle, for every channel: STEP = 0 or |target-current| <= STEP -> current <= target; else current moves STEP toward target; no overshoot, no wrap.
REQ-025 current changes only on update cycle; a target written mid-frame affects pulses from the next frame.
REQ-026 servo[i] <= enable and (frame counter < PULSE_MIN + current[i]), compare at frame-counter width with zero extension; one-clk registered latency.
REQ-027 Pulse width in ticks = PULSE_MIN + current[i]; in clk cycles = that * TICK_DIV.
REQ-028 enable low forces all servo low next clk; counters, targets and slewing continue; enable high resumes from current frame position.
REQ-029 All channels share one frame; rising edges aligned on the frame-counter-0 boundary.

Reset
REQ-030 While rst high: divider, frame counter = 0; target[i] = current[i] = 2^(PW-1); servo = 0; frame_start = 0; wr_ready = 1.
REQ-031 rst asserted mid-pulse drops servo low asynchronously, no wait for clk.
REQ-032 After rst release, first tic occurs TICK_DIV clks later; first frame_start after PERIOD*TICK_DIV clks.

Verification (defaults)
REQ-033 Reset, no writes -> every channel pulse 174 ticks = 16356 clks high, period 192512 clks, edges aligned.
REQ-034 Write ch2 pos 255 -> ch2 width at frame k after write = 46 + min(128+4k, 255): 178, 182, ... reaching 301 on frame 32 and holding; other channels stay 174.
REQ-035 Write ch0 pos 0 with STEP=0 build -> next frame ch0 width exactly 46 ticks = 4324 clks.
REQ-036 wr_en held across update cycle -> wr_ready low that cycle only, write accepted next cycle, exactly one target update.
REQ-037 rst pulsed mid-pulse and mid-slew -> servo 0 immediately; after release all channels back to 174-tick pulses; pre-reset targets lost.
REQ-038 enable low 3 frames while slewing ch1 -> servo all 0; on re-enable ch1 width reflects 3 frames of slew progress.
